pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 162 ++++++++++++++++
 tb/tb_pc_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- fetch program counter with branch/jump redirect and a one-entry
// redirect buffer that carries a redirect across a stall.
//
// Parameters
//   RESET_PC   fetch address after reset
//   EXC_PC     exception vector (used only when PC_UNIT_EXC_EN is defined)
//
// Ports
//   clk        single clock, all state on rising edge
//   reset      synchronous active-high reset
//   stall      high freezes pc_f; a taken redirect is buffered instead
//   br_op[3:0] D-stage control op (none/j/jr/beq/bne/blez/bgtz/bltz/bgez)
//   pc_d       PC of the D-stage instruction
//   imm26      D-stage instruction index / offset field
//   rs_val     forwarded rs operand
//   rt_val     forwarded rt operand
//   exc_req    exception request        (PC_UNIT_EXC_EN only)
//   eret       exception return         (PC_UNIT_EXC_EN only)
//   epc        exception return address (PC_UNIT_EXC_EN only)
//   pc_f       registered fetch address
//   pc4_f      pc_f + 4
//   taken      combinational redirect decision for the current D-stage op
//   pending    redirect buffer holds a target not yet loaded
//   misalign   one-cycle pulse after a taken jr whose rs_val[1:0] != 0
//
// Build option: define PC_UNIT_EXC_EN to add the exception/eret inputs.
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [3:0]  br_op,
    input  logic [31:0] pc_d,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
`ifdef PC_UNIT_EXC_EN
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
`endif
    output logic [31:0] pc_f,
    output logic [31:0] pc4_f,
    output logic        taken,
    output logic        pending,
    output logic        misalign
);

    localparam logic [3:0] OP_J    = 4'b0001;
    localparam logic [3:0] OP_JR   = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b0011;
    localparam logic [3:0] OP_BNE  = 4'b0100;
    localparam logic [3:0] OP_BLEZ = 4'b0101;
    localparam logic [3:0] OP_BGTZ = 4'b0110;
    localparam logic [3:0] OP_BLTZ = 4'b0111;
    localparam logic [3:0] OP_BGEZ = 4'b1000;

    // Exception controls; tied off in the default build so one datapath
    // serves both configurations.
    logic        exc_hit;
    logic        eret_hit;
    logic [31:0] epc_word;

`ifdef PC_UNIT_EXC_EN
    assign exc_hit  = exc_req;
    assign eret_hit = eret;
    assign epc_word = epc & ~32'd3;
`else
    assign exc_hit  = 1'b0;
    assign eret_hit = 1'b0;
    assign epc_word = 32'd0;
`endif

    logic [31:0] buf_pc;
    logic [31:0] pc_plus4_d;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic [31:0] target;
    logic        rs_neg;
    logic        rs_zero;
    logic        is_jr;

    logic [31:0] pc_next;
    logic [31:0] buf_next;
    logic        pending_next;
    logic        misalign_next;

    assign pc4_f      = pc_f + 32'd4;   // wraps naturally at 2^32
    assign pc_plus4_d = pc_d + 32'd4;
    assign br_target  = pc_plus4_d + {{14{imm26[15]}}, imm26[15:0], 2'b00};
    assign j_target   = {pc_plus4_d[31:28], imm26, 2'b00};
    assign jr_target  = {rs_val[31:2], 2'b00};
    assign rs_neg     = rs_val[31];
    assign rs_zero    = (rs_val == 32'd0);
    assign is_jr      = (br_op == OP_JR);

    // Redirect decision and target selection
    always_comb begin
        taken  = 1'b0;
        target = br_target;
        unique case (br_op)
            OP_J:    begin taken = 1'b1; target = j_target; end
            OP_JR:   begin taken = 1'b1; target = jr_target; end
            OP_BEQ:  taken = (rs_val == rt_val);
            OP_BNE:  taken = (rs_val != rt_val);
            OP_BLEZ: taken = rs_neg | rs_zero;
            OP_BGTZ: taken = ~rs_neg & ~rs_zero;
            OP_BLTZ: taken = rs_neg;
            OP_BGEZ: taken = ~rs_neg;
            default: taken = 1'b0;
        endcase
    end

    // Next fetch address, buffer and pending flag
    always_comb begin
        pc_next      = pc_f;
        buf_next     = buf_pc;
        pending_next = pending;
        if (exc_hit) begin
            pc_next      = EXC_PC;
            pending_next = 1'b0;
        end else if (eret_hit) begin
            pc_next      = epc_word;
            pending_next = 1'b0;
        end else if (!stall) begin
            // A live redirect is newer than anything buffered, so it wins.
            if (taken)
                pc_next = target;
            else if (pending)
                pc_next = buf_pc;
            else
                pc_next = pc4_f;
            pending_next = 1'b0;
        end else if (taken) begin
            buf_next     = target;
            pending_next = 1'b1;
        end
    end

    // Flag the misaligned jr at the cycle it is accepted, live or buffered.
    assign misalign_next = ~exc_hit & ~eret_hit & taken & is_jr & (rs_val[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f     <= RESET_PC;
            buf_pc   <= 32'd0;
            pending  <= 1'b0;
            misalign <= 1'b0;
        end else begin
            pc_f     <= pc_next;
            buf_pc   <= buf_next;
            pending  <= pending_next;
            misalign <= misalign_next;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [3:0]  br_op;
    logic [31:0] pc_d;
    logic [25:0] imm26;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
`ifdef PC_UNIT_EXC_EN
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
`endif
    logic [31:0] pc_f;
    logic [31:0] pc4_f;
    logic        taken;
    logic        pending;
    logic        misalign;

    int checks   = 0;
    int failures = 0;

    pc_unit dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .br_op    (br_op),
        .pc_d     (pc_d),
        .imm26    (imm26),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
`ifdef PC_UNIT_EXC_EN
        .exc_req  (exc_req),
        .eret     (eret),
        .epc      (epc),
`endif
        .pc_f     (pc_f),
        .pc4_f    (pc4_f),
        .taken    (taken),
        .pending  (pending),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Signed-compare branch table: op, rs, expected taken
    logic [3:0]  cmp_op [12] = '{4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd6,
                                 4'd7, 4'd7, 4'd7, 4'd8, 4'd8, 4'd8};
    logic [31:0] cmp_rs [12] = '{32'h0, 32'h8000_0000, 32'h1,
                                 32'h0, 32'h8000_0000, 32'h1,
                                 32'h0, 32'h8000_0000, 32'h1,
                                 32'h0, 32'h8000_0000, 32'h1};
    logic        cmp_tk [12] = '{1'b1, 1'b1, 1'b0,   // blez
                                 1'b0, 1'b0, 1'b1,   // bgtz
                                 1'b0, 1'b1, 1'b0,   // bltz
                                 1'b1, 1'b0, 1'b1};  // bgez

    initial begin
        reset  = 1'b1;
        stall  = 1'b0;
        br_op  = 4'd0;
        pc_d   = 32'd0;
        imm26  = 26'd0;
        rs_val = 32'd0;
        rt_val = 32'd0;
`ifdef PC_UNIT_EXC_EN
        exc_req = 1'b0;
        eret    = 1'b0;
        epc     = 32'd0;
`endif
        // Reset applied with stall and a taken op present
        stall = 1'b1;
        br_op = 4'd1;
        tick();
        tick();
        check("rst_pc", pc_f, 32'h3000);
        check("rst_pend", pending, 0);
        check("rst_mis", misalign, 0);
        check("rst_pc4", pc4_f, 32'h3004);
        reset = 1'b0;
        stall = 1'b0;
        br_op = 4'd0;

        // Sequential fetch
        tick(); check("seq1", pc_f, 32'h3004);
        tick(); check("seq2", pc_f, 32'h3008);
        tick(); check("seq3", pc_f, 32'h300C);

        // beq taken, backward offset -2 words
        pc_d = 32'h3010; imm26 = 26'h000FFFE; rs_val = 32'd5; rt_val = 32'd5; br_op = 4'd3;
        #1 check("beq_tk", taken, 1);
        tick(); check("beq_pc", pc_f, 32'h300C);
        rt_val = 32'd6;
        #1 check("beq_nt", taken, 0);
        tick(); check("beq_nt_pc", pc_f, 32'h3010);
        br_op = 4'd4;
        #1 check("bne_tk", taken, 1);
        br_op = 4'd9;
        #1 check("op_inval", taken, 0);
        br_op = 4'd0;
        rt_val = 32'd0;

        // Jump during stall is buffered, loaded on release
        stall = 1'b1; br_op = 4'd1; imm26 = 26'h0000C40; pc_d = 32'h3020;
        #1 check("j_tk", taken, 1);
        tick(); check("stl_hold", pc_f, 32'h3010); check("stl_pend", pending, 1);
        br_op = 4'd0;
        tick(); check("stl_hold2", pc_f, 32'h3010); check("stl_pend2", pending, 1);
        stall = 1'b0;
        tick(); check("stl_rel", pc_f, 32'h3100); check("rel_pend", pending, 0);
        tick(); check("post_rel", pc_f, 32'h3104);

        // Newer redirect during stall overwrites the buffer
        stall = 1'b1; br_op = 4'd1; imm26 = 26'h0000C40;
        tick();
        imm26 = 26'h0000C80;
        tick(); check("ovw_hold", pc_f, 32'h3104);
        br_op = 4'd0; stall = 1'b0;
        tick(); check("ovw_pc", pc_f, 32'h3200); check("ovw_pend", pending, 0);

        // Live redirect on release beats the buffered one
        stall = 1'b1; br_op = 4'd1; imm26 = 26'h0000C40;
        tick();
        stall = 1'b0; imm26 = 26'h0000C80;
        tick(); check("live_pri", pc_f, 32'h3200); check("live_pend", pending, 0);
        br_op = 4'd0;
        tick(); check("live_seq", pc_f, 32'h3204);

        // Misaligned jr
        br_op = 4'd2; rs_val = 32'h0000_3007;
        tick(); check("jr_pc", pc_f, 32'h3004); check("jr_mis", misalign, 1);
        br_op = 4'd0;
        tick(); check("jr_mis_off", misalign, 0); check("jr_seq", pc_f, 32'h3008);

        // Reset mid-stall discards the buffered redirect
        stall = 1'b1; br_op = 4'd1; imm26 = 26'h0000C40;
        tick(); check("rb_pend", pending, 1);
        reset = 1'b1; br_op = 4'd0;
        tick(); check("rb_pc", pc_f, 32'h3000); check("rb_pend0", pending, 0);
        reset = 1'b0; stall = 1'b0;
        tick(); check("rb_seq", pc_f, 32'h3004);

        // Wrap-around at top of address space
        br_op = 4'd2; rs_val = 32'hFFFF_FFFC;
        tick(); check("wrap_pc", pc_f, 32'hFFFF_FFFC); check("wrap_pc4", pc4_f, 32'h0);
        check("wrap_mis", misalign, 0);
        br_op = 4'd0;
        tick(); check("wrap_seq", pc_f, 32'h0);

        // Signed zero-compare branches (combinational)
        stall = 1'b1;
        for (int i = 0; i < 12; i++) begin
            br_op = cmp_op[i]; rs_val = cmp_rs[i];
            #1 check($sformatf("cmp%0d", i), taken, cmp_tk[i]);
        end
        br_op = 4'd0;
        stall = 1'b0;

`ifdef PC_UNIT_EXC_EN
        stall = 1'b1; br_op = 4'd1; pc_d = 32'h3020; imm26 = 26'h0000C40;
        tick(); check("exc_pend1", pending, 1);
        exc_req = 1'b1;
        tick(); check("exc_pc", pc_f, 32'h4180); check("exc_pend0", pending, 0);
        exc_req = 1'b0; stall = 1'b0; br_op = 4'd0;
        tick(); check("exc_seq", pc_f, 32'h4184);
        eret = 1'b1; epc = 32'h3043;
        tick(); check("eret_pc", pc_f, 32'h3040);
        eret = 1'b0;
        tick(); check("eret_seq", pc_f, 32'h3044);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
